// File: rtl/rvvi_frame_receiver.sv
// RVVI trace link receiver: filters and sequences MAC RX frames, returns cumulative ack frames.
// Optional statistics counters are built only when RVVI_RX_STATS_EN is defined.
//
// state | meaning
// SYNC  | discard beats until the first end-of-frame after reset
// RECV  | collecting beats of a candidate trace frame
// DROP  | frame already rejected, swallow beats until its last one
// IDLE  | no ack in flight (TX)
// SEND  | streaming the 6-beat ack frame (TX)
module rvvi_frame_receiver #(
  parameter int XLEN              = 64,
  parameter int MAX_CSRS          = 5,
  parameter int RVVI_WIDTH        = 128 + 4*XLEN + MAX_CSRS*(XLEN+16),
  parameter int FRAME_COUNT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  RxAxiData,
  input  logic [3:0]                   RxAxiKeep,
  input  logic                         RxAxiValid,
  input  logic                         RxAxiLast,
  output logic [31:0]                  TxAxiData,
  output logic [3:0]                   TxAxiKeep,
  output logic                         TxAxiValid,
  output logic                         TxAxiLast,
  input  logic                         TxAxiReady,
  input  logic [47:0]                  OwnMac,
  input  logic [47:0]                  PeerMac,
  input  logic [15:0]                  EthType,
  input  logic [15:0]                  AckType,
  output logic                         RvviValid,
  output logic [RVVI_WIDTH-1:0]        Rvvi,
  output logic [FRAME_COUNT_WIDTH-1:0] RvviFrameCount,
  output logic                         SeqError,
  output logic                         DropPulse,
  output logic [31:0]                  StatGood,
  output logic [31:0]                  StatDrop,
  output logic [31:0]                  StatDup
);
  localparam int FRAME_WORDS = (192 + RVVI_WIDTH + 31) / 32;
  localparam int BUF_W       = (FRAME_WORDS - 1) * 32;
  localparam int BEAT_W      = $clog2(FRAME_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {SYNC, RECV, DROP} rxState_t;
  typedef enum logic {IDLE, SEND} txState_t;

  rxState_t rxState, rxNext;
  txState_t txState, txNext;

  logic [BEAT_W-1:0]            beatsLeft;
  logic [BUF_W-1:0]             rxBuf;
  logic [BUF_W+31:0]            frameFull;
  logic [FRAME_COUNT_WIDTH-1:0] frameCount, expected;
  logic                         rxShift, frameEnd, dropNow, headerOk;
  logic                         isNew, isDup, ackReq;
  logic                         ackPending;
  logic [FRAME_COUNT_WIDTH-1:0] ackPendCount, ackCount;
  logic [63:0]                  ackCount64;
  logic [2:0]                   txBeat;
  logic                         unusedBits;

  // Non-last beats shift in from the top, so beat k ends up at [32k+:32] once the last beat arrives.
  assign frameFull  = {RxAxiData, rxBuf};
  assign frameCount = frameFull[128 +: FRAME_COUNT_WIDTH];
  assign headerOk   = (frameFull[47:0] == OwnMac) && (frameFull[111:96] == EthType);
  assign isNew      = frameEnd && headerOk && (frameCount == expected);
  assign isDup      = frameEnd && headerOk && (frameCount < expected);
  assign ackReq     = isNew || isDup;
  assign unusedBits = ^{frameFull[127:112], frameFull[BUF_W+31:192+RVVI_WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rxState <= SYNC;
    else       rxState <= rxNext;
  end

  always_comb begin
    rxNext = rxState;
    case (rxState)
      SYNC: if (RxAxiValid && RxAxiLast) rxNext = RECV;
      RECV: if (RxAxiValid && !RxAxiLast && (RxAxiKeep != 4'hF || beatsLeft == '0)) rxNext = DROP;
      DROP: if (RxAxiValid && RxAxiLast) rxNext = RECV;
      default: rxNext = SYNC;
    endcase
  end

  always_comb begin
    rxShift  = 1'b0;
    frameEnd = 1'b0;
    dropNow  = 1'b0;
    case (rxState)
      RECV: if (RxAxiValid) begin
        if (!RxAxiLast)             rxShift  = 1'b1;
        else if (beatsLeft == '0)   frameEnd = 1'b1;
        else                        dropNow  = 1'b1;
      end
      DROP: dropNow = RxAxiValid && RxAxiLast;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beatsLeft <= LAST_BEAT;
      rxBuf     <= '0;
    end else begin
      if (rxState != RECV || rxNext != RECV || (RxAxiValid && RxAxiLast)) beatsLeft <= LAST_BEAT;
      else if (RxAxiValid)                                              beatsLeft <= beatsLeft - 1'b1;
      if (rxShift) rxBuf <= {RxAxiData, rxBuf[BUF_W-1:32]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RvviValid      <= 1'b0;
      SeqError       <= 1'b0;
      DropPulse      <= 1'b0;
      Rvvi           <= '0;
      RvviFrameCount <= '0;
      expected       <= '0;
    end else begin
      RvviValid <= isNew;
      SeqError  <= frameEnd && headerOk && (frameCount > expected);
      DropPulse <= dropNow || (frameEnd && !headerOk);
      if (isNew) begin
        Rvvi           <= frameFull[192 +: RVVI_WIDTH];
        RvviFrameCount <= frameCount;
        expected       <= expected + 1'b1;
      end
    end
  end

  // Single pending slot; a newer request overwrites it because acks are cumulative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ackPending   <= 1'b0;
      ackPendCount <= '0;
    end else if (ackReq) begin
      ackPending   <= 1'b1;
      ackPendCount <= frameCount;
    end else if (txState == IDLE) begin
      ackPending   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState  <= IDLE;
      txBeat   <= '0;
      ackCount <= '0;
    end else begin
      txState <= txNext;
      if (txState == IDLE && txNext == SEND) begin
        txBeat   <= '0;
        ackCount <= ackPendCount;
      end else if (txState == SEND && TxAxiReady) begin
        txBeat <= txBeat + 1'b1;
      end
    end
  end

  always_comb begin
    txNext = txState;
    case (txState)
      IDLE: if (ackPending) txNext = SEND;
      SEND: if (TxAxiReady && txBeat == 3'd5) txNext = IDLE;
      default: txNext = IDLE;
    endcase
  end

  assign ackCount64 = 64'(ackCount);

  always_comb begin
    TxAxiKeep  = 4'hF;
    TxAxiValid = (txState == SEND);
    TxAxiLast  = (txState == SEND) && (txBeat == 3'd5);
    TxAxiData  = '0;
    if (txState == SEND) begin
      case (txBeat)
        3'd0:    TxAxiData = PeerMac[31:0];
        3'd1:    TxAxiData = {OwnMac[15:0], PeerMac[47:32]};
        3'd2:    TxAxiData = OwnMac[47:16];
        3'd3:    TxAxiData = {AckType, EthType};
        3'd4:    TxAxiData = ackCount64[31:0];
        3'd5:    TxAxiData = ackCount64[63:32];
        default: TxAxiData = '0;
      endcase
    end
  end

`ifdef RVVI_RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StatGood <= '0;
      StatDrop <= '0;
      StatDup  <= '0;
    end else begin
      if (isNew && StatGood != 32'hFFFF_FFFF) StatGood <= StatGood + 32'd1;
      if ((dropNow || (frameEnd && !headerOk)) && StatDrop != 32'hFFFF_FFFF) StatDrop <= StatDrop + 32'd1;
      if (isDup && StatDup != 32'hFFFF_FFFF) StatDup <= StatDup + 32'd1;
    end
  end
`else
  assign StatGood = '0;
  assign StatDrop = '0;
  assign StatDup  = '0;
`endif
endmodule
